// File: rtl/reset_sequencer.sv
// reset_sequencer: filters PLL lock, holds all resets, then releases NUM_CH channels in staged order
// Define RSTSEQ_WDOG_EN to add the lock watchdog that pulses o_pll_rst; otherwise o_pll_rst is tied low.
module reset_sequencer #(
   parameter int NUM_CH      = 4,
   parameter int LOCK_FILTER = 16,
   parameter int HOLD_CYCLES = 100000,
   parameter int STAGE_GAP   = 16,
   parameter int SOFT_HOLD   = 64,
   parameter int WDOG_CYCLES = 1000000,
   parameter int PLL_RST_LEN = 8
) (
   input  logic              i_clkin,
   input  logic              i_reset,
   input  logic              i_locked,
   input  logic              i_soft_req,
   output logic [NUM_CH-1:0] o_rst_out,
   output logic              o_rst_done,
   output logic              o_seq_busy,
   output logic [7:0]        o_lock_loss_cnt,
   output logic              o_pll_rst
);
   localparam int M1   = LOCK_FILTER > HOLD_CYCLES ? LOCK_FILTER : HOLD_CYCLES;
   localparam int M2   = STAGE_GAP > SOFT_HOLD ? STAGE_GAP : SOFT_HOLD;
   localparam int MAXC = M1 > M2 ? M1 : M2;
   localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
   localparam int IW   = $clog2(NUM_CH) + 1;
   localparam logic [2:0] WAIT_LOCK = 3'd0;
   localparam logic [2:0] FILTER    = 3'd1;
   localparam logic [2:0] HOLD      = 3'd2;
   localparam logic [2:0] STAGE     = 3'd3;
   localparam logic [2:0] RUN       = 3'd4;
   localparam logic [2:0] SOFT      = 3'd5;
   logic              r_meta, r_lock_s;
   logic [2:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_idx;
   logic [NUM_CH-1:0] r_rst;
   logic [7:0]        r_llc;
   logic [CW-1:0]     w_lim;
   logic [NUM_CH-1:0] w_mask;
   logic              w_last, w_lost;
   assign w_lim  = (r_state == HOLD) ? CW'(HOLD_CYCLES - 1) : CW'(SOFT_HOLD - 1);
   assign w_mask = NUM_CH'(1) << r_idx;
   assign w_last = r_idx == IW'(NUM_CH - 1);
   // A drop during FILTER just restarts filtering; only drops after it count as lock losses.
   assign w_lost = !r_lock_s && (r_state == HOLD || r_state == STAGE || r_state == RUN || r_state == SOFT);
   always_ff @(posedge i_clkin) begin
      if (i_reset) begin
         r_meta   <= 1'b0;
         r_lock_s <= 1'b0;
         r_state  <= WAIT_LOCK;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_rst    <= '1;
         r_llc    <= '0;
      end else begin
         r_meta   <= i_locked;
         r_lock_s <= r_meta;
         if (w_lost) begin
            r_state <= WAIT_LOCK;
            r_rst   <= '1;
            r_cnt   <= '0;
            r_llc   <= (r_llc == 8'hFF) ? r_llc : r_llc + 8'd1;
         end else begin
            case (r_state)
               WAIT_LOCK: begin
                  r_rst <= '1;
                  r_cnt <= '0;
                  if (r_lock_s) r_state <= FILTER;
               end
               FILTER: begin
                  if (!r_lock_s) begin
                     r_state <= WAIT_LOCK;
                     r_cnt   <= '0;
                  end else if (r_cnt == CW'(LOCK_FILTER - 1)) begin
                     r_state <= HOLD;
                     r_cnt   <= '0;
                  end else r_cnt <= r_cnt + CW'(1);
               end
               HOLD, SOFT: begin
                  if (r_cnt == w_lim) begin
                     r_cnt    <= '0;
                     r_idx    <= IW'(1);
                     r_rst[0] <= 1'b0;
                     r_state  <= (NUM_CH == 1) ? RUN : STAGE;
                  end else r_cnt <= r_cnt + CW'(1);
               end
               STAGE: begin
                  if (r_cnt == CW'(STAGE_GAP - 1)) begin
                     r_cnt <= '0;
                     r_rst <= r_rst & ~w_mask;
                     r_idx <= r_idx + IW'(1);
                     if (w_last) r_state <= RUN;
                  end else r_cnt <= r_cnt + CW'(1);
               end
               RUN: begin
                  if (i_soft_req) begin
                     r_state <= SOFT;
                     r_rst   <= '1;
                     r_cnt   <= '0;
                  end
               end
               default: begin
                  r_state <= WAIT_LOCK;
                  r_rst   <= '1;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end
   assign o_rst_out       = r_rst;
   assign o_rst_done      = r_state == RUN;
   assign o_seq_busy      = r_state != RUN;
   assign o_lock_loss_cnt = r_llc;
`ifdef RSTSEQ_WDOG_EN
   localparam int WW = WDOG_CYCLES > 1 ? $clog2(WDOG_CYCLES) : 1;
   localparam int PW = PLL_RST_LEN > 1 ? $clog2(PLL_RST_LEN) : 1;
   logic [WW-1:0] r_wdog;
   logic [PW-1:0] r_pcnt;
   logic          r_pll;
   logic          w_fire;
   assign w_fire = r_wdog == WW'(WDOG_CYCLES - 1);
   always_ff @(posedge i_clkin) begin
      if (i_reset || !(r_state == WAIT_LOCK || r_state == FILTER)) begin
         r_wdog <= '0;
         r_pcnt <= '0;
         r_pll  <= 1'b0;
      end else begin
         r_wdog <= w_fire ? '0 : r_wdog + WW'(1);
         if (w_fire) begin
            r_pll  <= 1'b1;
            r_pcnt <= '0;
         end else if (r_pll) begin
            r_pcnt <= r_pcnt + PW'(1);
            if (r_pcnt == PW'(PLL_RST_LEN - 1)) r_pll <= 1'b0;
         end
      end
   end
   assign o_pll_rst = r_pll;
`else
   // Always 0; referencing the watchdog parameters keeps them used when the feature is compiled out.
   assign o_pll_rst = (WDOG_CYCLES < 0) || (PLL_RST_LEN < 0);
`endif
endmodule
